// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - two-to-one fetch/LSU memory-port arbiter
// Round-robin with request lock; an owner FIFO routes in-order responses back.
module miriscv_mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk_i,
  input  logic                               arstn_i,
  input  logic                               i_req_i,
  input  logic [XLEN-1:0]                    i_addr_i,
  output logic                               i_gnt_o,
  output logic                               i_rvalid_o,
  output logic [XLEN-1:0]                    i_rdata_o,
  input  logic                               d_req_i,
  input  logic                               d_we_i,
  input  logic [XLEN/8-1:0]                  d_be_i,
  input  logic [XLEN-1:0]                    d_addr_i,
  input  logic [XLEN-1:0]                    d_wdata_i,
  output logic                               d_gnt_o,
  output logic                               d_rvalid_o,
  output logic [XLEN-1:0]                    d_rdata_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [XLEN/8-1:0]                  mem_be_o,
  output logic [XLEN-1:0]                    mem_addr_o,
  output logic [XLEN-1:0]                    mem_wdata_o,
  input  logic                               mem_gnt_i,
  input  logic                               mem_rvalid_i,
  input  logic [XLEN-1:0]                    mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [MAX_OUTSTANDING-1:0] own_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       last_grant_q, lock_q, lock_port_q, err_q;
  logic                       full, empty, lock_eff, sel, accept, pop, head;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(MAX_OUTSTANDING));
  assign empty    = (count_q == '0);
  // A locked port that drops req releases the lock immediately.
  assign lock_eff = lock_q & (lock_port_q ? d_req_i : i_req_i);

  always_comb begin
    sel = 1'b0;
    if (lock_eff)                 sel = lock_port_q;
    else if (i_req_i && d_req_i)  sel = ~last_grant_q;
    else if (d_req_i)             sel = 1'b1;
  end

  assign mem_req_o   = (i_req_i | d_req_i) & ~full & arstn_i;
  assign mem_we_o    = sel ? d_we_i    : 1'b0;
  assign mem_be_o    = sel ? d_be_i    : '1;
  assign mem_addr_o  = sel ? d_addr_i  : i_addr_i;
  assign mem_wdata_o = sel ? d_wdata_i : '0;

  assign accept  = mem_req_o & mem_gnt_i;
  assign i_gnt_o = accept & ~sel;
  assign d_gnt_o = accept & sel;

  assign pop        = mem_rvalid_i & ~empty;
  assign head       = own_q[rd_ptr_q];
  assign i_rvalid_o = pop & ~head;
  assign d_rvalid_o = pop & head;
  assign i_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

  assign outstanding_o = count_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      own_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
      lock_q       <= 1'b0;
      lock_port_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        own_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= bump(wr_ptr_q);
        last_grant_q    <= sel;
      end
      if (pop) rd_ptr_q <= bump(rd_ptr_q);
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      lock_q      <= mem_req_o & ~mem_gnt_i;
      lock_port_q <= sel;
      if (mem_rvalid_i && empty) err_q <= 1'b1;
    end
  end

endmodule
